vga_timing_gen: RTL

//  Generates VGA raster timing for the display path: pixel-rate tick, DAC pixel clock,

---
 rtl/vga_timing_gen.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel tick, DAC pixel clock, sync, blanking, raw x/y.
// Latency: every output is registered; sync/blank are decoded from next-state counters.
// Backpressure: none, free-running raster driven only by clk and rst_n.
//
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   x, y                raw raster counters (0..H_TOTAL-1, 0..V_TOTAL-1)
//   hsync, vsync        sync outputs, asserted level set by H_POL / V_POL
//   blank_n             1 inside the active video region
//   sync_n              DAC composite sync, tied to 0
//   vga_clk             DAC pixel clock, rising edge mid-pixel
//   pix_tick            1-clk strobe on the last clk of each pixel
//   line_start          1-clk pulse on the first clk of each line
//   frame_start         1-clk pulse on the first clk of each frame
//
// Build option: define VGA_SYNC_DELAY_EN to delay hsync/vsync/blank_n by one
// pixel relative to x/y (lines up with a registered RGB stage downstream).
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       sync_n,
  output logic       vga_clk,
  output logic       pix_tick,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ACT = (H_POL != 0);
  localparam logic VS_ACT = (V_POL != 0);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic [9:0]       x_nxt;
  logic [9:0]       y_nxt;
  logic             tick_now;
  logic             x_wrap;
  logic             y_wrap;

  // Source counters for the sync/blank decode and when they are loaded.
  logic [9:0]       dec_x;
  logic [9:0]       dec_y;
  logic             dec_load;
  logic             hs_src;
  logic             vs_src;
  logic             bn_src;

  always_comb begin
    tick_now = (div_cnt == DIV_LAST);
    div_nxt  = tick_now ? '0 : div_cnt + 1'b1;
    x_wrap   = tick_now && (x == X_LAST);
    y_wrap   = x_wrap && (y == Y_LAST);
    x_nxt    = x;
    y_nxt    = y;
    if (tick_now) begin
      x_nxt = x_wrap ? 10'd0 : x + 10'd1;
    end
    if (x_wrap) begin
      y_nxt = y_wrap ? 10'd0 : y + 10'd1;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  // Decode the pixel that is ending and load it only when x advances, so the
  // sync/blank outputs trail x/y by exactly one pixel.
  always_comb begin
    dec_x    = x;
    dec_y    = y;
    dec_load = tick_now;
  end
`else
  // Decode the counters' next state so sync/blank land on the same edge as x/y.
  always_comb begin
    dec_x    = x_nxt;
    dec_y    = y_nxt;
    dec_load = 1'b1;
  end
`endif

  always_comb begin
    hs_src = ((dec_x >= HS_START) && (dec_x < HS_END)) ? HS_ACT : ~HS_ACT;
    vs_src = ((dec_y >= VS_START) && (dec_y < VS_END)) ? VS_ACT : ~VS_ACT;
    bn_src = (dec_x < X_ACT) && (dec_y < Y_ACT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      x           <= 10'd0;
      y           <= 10'd0;
      vga_clk     <= 1'b0;
      pix_tick    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= div_nxt;
      x           <= x_nxt;
      y           <= y_nxt;
      // Strobes are decoded from next-state divider so they are true in the
      // same cycle the divider holds the matching count.
      vga_clk     <= (div_nxt >= DIV_HALF);
      pix_tick    <= (div_nxt == DIV_LAST);
      // Only wraps generate pulses, so the (0,0) after reset stays silent.
      line_start  <= x_wrap;
      frame_start <= y_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync   <= ~HS_ACT;
      vsync   <= ~VS_ACT;
      blank_n <= 1'b0;
    end else if (dec_load) begin
      hsync   <= hs_src;
      vsync   <= vs_src;
      blank_n <= bn_src;
    end
  end

  assign sync_n = 1'b0;

endmodule
